// File: rtl/fft_reorder_stream.sv
// FFT output stage: reorders bit-reversed frames to natural bin order through a
// two-bank ping-pong RAM and streams them out on a valid/ready interface.
module fft_reorder_stream #(
  parameter int LGSIZE     = 8,
  parameter int WIDTH      = 18,
  parameter int OPT_BITREV = 1,
  parameter int FCNTW      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_ce,
  input  logic                  i_sync,
  input  logic [2*WIDTH-1:0]    i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [2*WIDTH-1:0]    o_data,
  output logic [LGSIZE-1:0]     o_bin,
  output logic                  o_first,
  output logic                  o_last,
  output logic [FCNTW-1:0]      o_frame,
  output logic                  o_overrun,
  output logic                  o_desync,
  input  logic                  i_clr_err
);

  localparam int                DW       = 2 * WIDTH;
  localparam int                N        = 1 << LGSIZE;
  localparam logic [LGSIZE-1:0] LAST_BIN = '1;
  localparam logic [LGSIZE-1:0] ONE      = LGSIZE'(1);

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_FILL = 2'd1,
    WR_DROP = 2'd2
  } wr_state_t;

  function automatic logic [LGSIZE-1:0] bitrev(input logic [LGSIZE-1:0] x);
    logic [LGSIZE-1:0] r;
    for (int b = 0; b < LGSIZE; b++) r[b] = x[LGSIZE-1-b];
    return r;
  endfunction

  // Writer state
  wr_state_t         r_wr_state, w_wr_state_nxt;
  logic [LGSIZE-1:0] r_wr_cnt, w_wr_cnt_nxt;
  logic              r_wr_bank, w_wr_bank_nxt;
  logic [1:0]        r_full;
  logic              w_we;
  logic [LGSIZE-1:0] w_wr_idx;
  logic [LGSIZE-1:0] w_wr_addr;
  logic              w_set_full;
  logic              w_set_ovr;
  logic              w_set_des;

  // Reader state
  logic              r_iss_bank;
  logic [LGSIZE-1:0] r_rd_cnt;
  logic              r_s1_valid;
  logic [LGSIZE-1:0] r_s1_bin;
  logic [DW-1:0]     r_ram_q;
  logic              r_sk_valid;
  logic [DW-1:0]     r_sk_data;
  logic [LGSIZE-1:0] r_sk_bin;
  logic              r_o_valid;
  logic [DW-1:0]     r_o_data;
  logic [LGSIZE-1:0] r_o_bin;
  logic [FCNTW-1:0]  r_frame;
  logic              r_overrun;
  logic              r_desync;
  logic              w_pop;
  logic [1:0]        w_occ;
  logic              w_issue;
  logic              w_iss_done;

  logic [DW-1:0]     r_mem [0:2*N-1];

  // Any frame start restarts the writer; only FILL's own bank is known free.
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_cnt_nxt   = r_wr_cnt;
    w_wr_bank_nxt  = r_wr_bank;
    w_we           = 1'b0;
    w_wr_idx       = r_wr_cnt;
    w_set_full     = 1'b0;
    w_set_ovr      = 1'b0;
    w_set_des      = 1'b0;
    if (i_ce) begin
      if (i_sync) begin
        w_set_des    = (r_wr_state == WR_FILL);
        w_wr_idx     = '0;
        w_wr_cnt_nxt = ONE;
        if (r_wr_state == WR_FILL || !r_full[r_wr_bank]) begin
          w_we           = 1'b1;
          w_wr_state_nxt = WR_FILL;
        end else begin
          w_set_ovr      = 1'b1;
          w_wr_state_nxt = WR_DROP;
        end
      end else begin
        case (r_wr_state)
          WR_FILL: begin
            w_we = 1'b1;
            if (r_wr_cnt == LAST_BIN) begin
              w_set_full     = 1'b1;
              w_wr_bank_nxt  = ~r_wr_bank;
              w_wr_cnt_nxt   = '0;
              w_wr_state_nxt = WR_IDLE;
            end else begin
              w_wr_cnt_nxt = r_wr_cnt + ONE;
            end
          end
          WR_DROP: begin
            if (r_wr_cnt == LAST_BIN) begin
              w_wr_cnt_nxt   = '0;
              w_wr_state_nxt = WR_IDLE;
            end else begin
              w_wr_cnt_nxt = r_wr_cnt + ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign w_wr_addr = (OPT_BITREV != 0) ? bitrev(w_wr_idx) : w_wr_idx;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_state <= WR_IDLE;
      r_wr_cnt   <= '0;
      r_wr_bank  <= 1'b0;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_wr_cnt   <= w_wr_cnt_nxt;
      r_wr_bank  <= w_wr_bank_nxt;
    end
  end

  // A bank is released once its last read is issued: its remaining words are
  // already held in the read pipeline, so back-to-back frames never overrun.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_full <= 2'b00;
    end else begin
      if (w_set_full) r_full[r_wr_bank] <= 1'b1;
      if (w_iss_done) r_full[r_iss_bank] <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[{r_wr_bank, w_wr_addr}] <= i_data;
    if (w_issue) r_ram_q <= r_mem[{r_iss_bank, r_rd_cnt}];
  end

  // Stream handshake: a word transfers on any clock where o_valid && i_ready;
  // while o_valid is high and i_ready low, every output field is held.
  assign w_pop      = r_o_valid && i_ready;
  assign w_occ      = 2'(r_o_valid) + 2'(r_sk_valid) + 2'(r_s1_valid);
  assign w_issue    = r_full[r_iss_bank] && (w_occ <= (w_pop ? 2'd2 : 2'd1));
  assign w_iss_done = w_issue && (r_rd_cnt == LAST_BIN);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_iss_bank <= 1'b0;
      r_rd_cnt   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_bin   <= '0;
    end else begin
      r_s1_valid <= w_issue;
      if (w_issue) begin
        r_s1_bin <= r_rd_cnt;
        r_rd_cnt <= r_rd_cnt + ONE;
        if (w_iss_done) r_iss_bank <= ~r_iss_bank;
      end
    end
  end

  // Output register plus one skid entry; the issue credit keeps total
  // occupancy at two so the skid can never overflow.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_o_valid  <= 1'b0;
      r_o_data   <= '0;
      r_o_bin    <= '0;
      r_sk_valid <= 1'b0;
      r_sk_data  <= '0;
      r_sk_bin   <= '0;
    end else if (!r_o_valid || w_pop) begin
      if (r_sk_valid) begin
        r_o_valid  <= 1'b1;
        r_o_data   <= r_sk_data;
        r_o_bin    <= r_sk_bin;
        r_sk_valid <= r_s1_valid;
        r_sk_data  <= r_ram_q;
        r_sk_bin   <= r_s1_bin;
      end else begin
        r_o_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_o_data <= r_ram_q;
          r_o_bin  <= r_s1_bin;
        end
      end
    end else if (r_s1_valid) begin
      r_sk_valid <= 1'b1;
      r_sk_data  <= r_ram_q;
      r_sk_bin   <= r_s1_bin;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_frame   <= '0;
      r_overrun <= 1'b0;
      r_desync  <= 1'b0;
    end else begin
      if (w_pop && r_o_bin == LAST_BIN) r_frame <= r_frame + 1'b1;
      if (w_set_ovr)      r_overrun <= 1'b1;
      else if (i_clr_err) r_overrun <= 1'b0;
      if (w_set_des)      r_desync <= 1'b1;
      else if (i_clr_err) r_desync <= 1'b0;
    end
  end

  assign o_valid   = r_o_valid;
  assign o_data    = r_o_data;
  assign o_bin     = r_o_bin;
  assign o_first   = r_o_valid && (r_o_bin == '0);
  assign o_last    = r_o_valid && (r_o_bin == LAST_BIN);
  assign o_frame   = r_frame;
  assign o_overrun = r_overrun;
  assign o_desync  = r_desync;

endmodule

// File: tb/tb_fft_reorder_stream.sv
// Bench for fft_reorder_stream with N=8: a bit-reversing instance checked through
// an expected-beat queue, plus a natural-order instance.
`timescale 1ns/1ps
module tb_fft_reorder_stream;
  localparam int LGSIZE = 3;
  localparam int WIDTH  = 8;
  localparam int FCNTW  = 16;
  localparam int N      = 8;
  localparam int DW     = 2 * WIDTH;
  localparam int EW     = DW + LGSIZE + FCNTW;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              i_reset_n, i_ce, i_sync, i_ready, i_clr_err;
  logic [DW-1:0]     i_data;
  logic              o_valid, o_first, o_last, o_overrun, o_desync;
  logic [DW-1:0]     o_data;
  logic [LGSIZE-1:0] o_bin;
  logic [FCNTW-1:0]  o_frame;

  logic              n_ce, n_sync, n_ready, n_clr;
  logic [DW-1:0]     n_data_in;
  logic              n_valid, n_first, n_last, n_overrun, n_desync;
  logic [DW-1:0]     n_data;
  logic [LGSIZE-1:0] n_bin;
  logic [FCNTW-1:0]  n_frame;

  fft_reorder_stream #(.LGSIZE(LGSIZE), .WIDTH(WIDTH), .OPT_BITREV(1), .FCNTW(FCNTW)) dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_ce(i_ce), .i_sync(i_sync), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_bin(o_bin),
    .o_first(o_first), .o_last(o_last), .o_frame(o_frame),
    .o_overrun(o_overrun), .o_desync(o_desync), .i_clr_err(i_clr_err)
  );

  fft_reorder_stream #(.LGSIZE(LGSIZE), .WIDTH(WIDTH), .OPT_BITREV(0), .FCNTW(FCNTW)) dut_nat (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_ce(n_ce), .i_sync(n_sync), .i_data(n_data_in),
    .o_valid(n_valid), .i_ready(n_ready), .o_data(n_data), .o_bin(n_bin),
    .o_first(n_first), .o_last(n_last), .o_frame(n_frame),
    .o_overrun(n_overrun), .o_desync(n_desync), .i_clr_err(n_clr)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  int            exp_frame = 0;
  logic [DW-1:0] cur_nat[N];

  typedef struct {
    logic [DW-1:0]     in_data;
    logic [DW-1:0]     exp_data;
    logic [LGSIZE-1:0] exp_bin;
  } vec_t;
  vec_t vecs[N];

  logic gap_en = 1'b0;
  logic gap_seen;
  int   gap_cnt, gap_beats;
  logic stall_run;

  function automatic logic [2:0] br3(input logic [2:0] x);
    return {x[0], x[1], x[2]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic ce, input logic sync, input logic [DW-1:0] d);
    i_ce = ce; i_sync = sync; i_data = d;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    i_ce = 1'b0; i_sync = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rand_nat();
    for (int k = 0; k < N; k++) cur_nat[k] = DW'($urandom);
  endtask

  task automatic send_frame(input bit push);
    if (push) begin
      for (int k = 0; k < N; k++) exp_q.push_back({cur_nat[k], LGSIZE'(k), FCNTW'(exp_frame)});
      exp_frame++;
    end
    for (int i = 0; i < N; i++) drive(1'b1, i == 0, cur_nat[br3(3'(i))]);
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || o_valid) && cyc < 400) begin @(posedge clk); #1; cyc++; end
    n_checks++;
    if (exp_q.size() != 0 || o_valid) begin
      n_fail++;
      $display("FAIL %s: %0d beats outstanding after %0d cycles, required 0", name, exp_q.size(), cyc);
    end
  endtask

  // Scoreboard: the head of the queue must be on the outputs whenever o_valid
  // is high, and is retired only when the beat is accepted.
  logic [EW-1:0]     e;
  logic [DW-1:0]     e_data;
  logic [LGSIZE-1:0] e_bin;
  logic [FCNTW-1:0]  e_frame;
  always @(negedge clk) begin
    if (i_reset_n && o_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got data=%0h bin=%0d frame=%0d, required no beat", o_data, o_bin, o_frame);
      end else begin
        e       = exp_q[0];
        e_data  = e[EW-1 -: DW];
        e_bin   = e[FCNTW +: LGSIZE];
        e_frame = e[FCNTW-1:0];
        if ({o_data, o_bin, o_first, o_last, o_frame} !==
            {e_data, e_bin, e_bin == 3'd0, e_bin == 3'd7, e_frame}) begin
          n_fail++;
          $display("FAIL beat: got data=%0h bin=%0d first=%0b last=%0b frame=%0d, required data=%0h bin=%0d first=%0b last=%0b frame=%0d",
                   o_data, o_bin, o_first, o_last, o_frame,
                   e_data, e_bin, e_bin == 3'd0, e_bin == 3'd7, e_frame);
        end
        if (i_ready) void'(exp_q.pop_front());
      end
    end
    if (gap_en && i_reset_n) begin
      if (o_valid) gap_seen = 1'b1;
      else if (gap_seen && gap_beats < 4 * N) gap_cnt++;
      if (o_valid && i_ready) gap_beats++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    vecs[0] = '{16'd0, 16'd0, 3'd0};
    vecs[1] = '{16'd4, 16'd1, 3'd1};
    vecs[2] = '{16'd2, 16'd2, 3'd2};
    vecs[3] = '{16'd6, 16'd3, 3'd3};
    vecs[4] = '{16'd1, 16'd4, 3'd4};
    vecs[5] = '{16'd5, 16'd5, 3'd5};
    vecs[6] = '{16'd3, 16'd6, 3'd6};
    vecs[7] = '{16'd7, 16'd7, 3'd7};

    i_reset_n = 1'b0; i_ce = 1'b0; i_sync = 1'b0; i_data = '0; i_ready = 1'b1; i_clr_err = 1'b0;
    n_ce = 1'b0; n_sync = 1'b0; n_data_in = '0; n_ready = 1'b1; n_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_init", {o_valid, o_data, o_bin, o_first, o_last, o_frame, o_overrun, o_desync}, 64'd0);
    i_reset_n = 1'b1;
    @(posedge clk); #1;

    // Bit-reversed frame from the vector table, with first-output latency
    for (int i = 0; i < N; i++)
      exp_q.push_back({vecs[i].exp_data, vecs[i].exp_bin, FCNTW'(exp_frame)});
    exp_frame++;
    for (int i = 0; i < N; i++) drive(1'b1, i == 0, vecs[i].in_data);
    i_ce = 1'b0; i_sync = 1'b0;
    @(negedge clk);
    check("lat_cycle0", o_valid, 1'b0);
    @(negedge clk);
    check("lat_cycle1", o_valid, 1'b0);
    @(negedge clk);
    check("lat_cycle2", o_valid, 1'b1);
    wait_drain("drain_table");
    check("frame_after_first", o_frame, 1);

    // Four back-to-back frames under continuous i_ce
    gap_seen = 1'b0; gap_cnt = 0; gap_beats = 0; gap_en = 1'b1;
    for (int f = 0; f < 4; f++) begin rand_nat(); send_frame(1); end
    idle(1);
    wait_drain("drain_b2b");
    gap_en = 1'b0;
    check("b2b_gaps", gap_cnt, 0);
    check("b2b_beats", gap_beats, 4 * N);
    check("b2b_overrun", o_overrun, 1'b0);
    check("b2b_frame", o_frame, 5);

    // Three frames while stalled: the third has no free bank
    i_ready = 1'b0;
    rand_nat(); send_frame(1);
    rand_nat(); send_frame(1);
    rand_nat(); send_frame(0);
    idle(4);
    check("ovr_set", o_overrun, 1'b1);
    check("ovr_no_desync", o_desync, 1'b0);
    i_ready = 1'b1;
    wait_drain("drain_overrun");
    check("ovr_frame", o_frame, 7);
    check("ovr_still_set", o_overrun, 1'b1);
    i_clr_err = 1'b1; @(posedge clk); #1; i_clr_err = 1'b0;
    check("ovr_cleared", o_overrun, 1'b0);

    // Sync re-asserted at wr_cnt=5: partial frame discarded
    rand_nat();
    for (int i = 0; i < 5; i++) drive(1'b1, i == 0, DW'(16'hDEAD + i));
    send_frame(1);
    idle(2);
    check("desync_set", o_desync, 1'b1);
    wait_drain("drain_desync");
    check("desync_frame", o_frame, 8);
    i_clr_err = 1'b1; @(posedge clk); #1; i_clr_err = 1'b0;
    check("desync_cleared", o_desync, 1'b0);

    // Random downstream stalls
    stall_run = 1'b1;
    fork
      begin
        for (int f = 0; f < 3; f++) begin
          int w;
          w = 0;
          while (exp_q.size() > N && w < 200) begin @(posedge clk); #1; w++; end
          rand_nat(); send_frame(1);
          idle($urandom_range(0, 4));
        end
        stall_run = 1'b0;
      end
      begin
        while (stall_run) begin
          i_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    i_ready = 1'b1;
    wait_drain("drain_stall");
    check("stall_overrun", o_overrun, 1'b0);
    check("stall_frame", o_frame, 11);

    // Asynchronous reset while a frame is being read out
    rand_nat(); send_frame(1);
    i_ce = 1'b0; i_sync = 1'b0;
    repeat (4) @(negedge clk);
    #2 i_reset_n = 1'b0;
    #1 check("reset_async", {o_valid, o_data, o_bin, o_first, o_last, o_frame, o_overrun, o_desync}, 64'd0);
    exp_q.delete();
    exp_frame = 0;
    repeat (2) @(negedge clk);
    i_reset_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, DW'(16'hBEEF + i));
    rand_nat(); send_frame(1);
    idle(1);
    wait_drain("drain_post_reset");
    check("post_reset_frame", o_frame, 1);

    // Natural-order instance passes data through unchanged
    for (int k = 0; k < N; k++) begin
      n_ce = 1'b1; n_sync = (k == 0); n_data_in = DW'(16'h1000 + k);
      @(posedge clk); #1;
    end
    n_ce = 1'b0; n_sync = 1'b0;
    idx = 0;
    repeat (20) begin
      @(negedge clk);
      if (n_valid && n_ready && idx < N) begin
        check("nat_data", n_data, 64'(16'h1000 + idx));
        check("nat_bin", n_bin, 64'(idx));
        idx++;
      end
    end
    check("nat_count", idx, N);
    check("nat_frame", n_frame, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
